wb_port_arbiter: RTL

- Shares the single register-file write port between two requesters:
  - the in-order pipeline result (ALU/CSR/jump link, from LSU stage);
  - returned load data from the data-memory interface, which may arrive late or out of step.
- Pipeline results always win. Losing load returns are buffered in a small FIFO and drained into idle port cycles.
- A starvation timer stalls the pipeline so queued loads can retire.
- Sits between the LSU stage and the register file, replacing direct write-back wiring.

---
 rtl/wb_port_arbiter_if.sv | 31 +++
 rtl/wb_port_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter_if.sv
// Write-back port arbiter bundle: pipeline result, load return and register-file write port.
// The arbiter connects as slave; the environment (LSU stage / memory side / regfile) as master.
interface wb_port_arbiter_if;
    logic        pipe_vld;
    logic [4:0]  pipe_rd;
    logic        pipe_rd_wen;
    logic [31:0] pipe_rd_data;
    logic        ld_vld;
    logic        ld_rdy;
    logic [4:0]  ld_rd;
    logic [31:0] ld_rd_data;
    logic        pipe_stall;
    logic        ld_pending;
    logic [4:0]  wb_rd;
    logic [31:0] wb_rd_data;
    logic        wb_rd_wen;

    modport master (
        output pipe_vld, pipe_rd, pipe_rd_wen, pipe_rd_data,
        output ld_vld, ld_rd, ld_rd_data,
        input  ld_rdy, pipe_stall, ld_pending,
        input  wb_rd, wb_rd_data, wb_rd_wen
    );

    modport slave (
        input  pipe_vld, pipe_rd, pipe_rd_wen, pipe_rd_data,
        input  ld_vld, ld_rd, ld_rd_data,
        output ld_rdy, pipe_stall, ld_pending,
        output wb_rd, wb_rd_data, wb_rd_wen
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline results win, load returns queue in a FIFO
// with a starvation stall. Optional macro WB_ARB_BYPASS_EN lets a lone load skip the FIFO.
module wb_port_arbiter #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic               CLK,
    input  logic               RSTN,
    wb_port_arbiter_if.slave   bus
);

    localparam int             PTR_W      = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE    = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [7:0]     STARVE_LIM = 8'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        QUEUED = 2'd1,
        STALL  = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;

    logic [PTR_W:0]      wr_ptr_r;
    logic [PTR_W:0]      rd_ptr_r;
    logic [PTR_W:0]      fill_s;
    logic [PTR_W-1:0]    head_idx_s;
    logic [PTR_W-1:0]    tail_idx_s;
    logic [4:0]          fifo_rd_r   [DEPTH];
    logic [31:0]         fifo_data_r [DEPTH];
    logic [DEPTH-1:0]    fifo_wen_r;

    logic [7:0]          starve_r;
    logic [7:0]          starve_nxt_s;

    logic                empty_s;
    logic                full_s;
    logic                stall_s;
    logic                pipe_win_s;
    logic                pop_s;
    logic                push_s;
    logic                bypass_s;
    logic                drain_s;

    logic [4:0]          wb_rd_r;
    logic [31:0]         wb_rd_data_r;
    logic                wb_rd_wen_r;
    logic [4:0]          wb_rd_nxt_s;
    logic [31:0]         wb_rd_data_nxt_s;
    logic                wb_rd_wen_nxt_s;

    assign fill_s     = wr_ptr_r - rd_ptr_r;
    assign head_idx_s = rd_ptr_r[PTR_W-1:0];
    assign tail_idx_s = wr_ptr_r[PTR_W-1:0];
    assign empty_s    = (wr_ptr_r == rd_ptr_r);
    assign full_s     = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                        (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);
    assign stall_s    = (state_r == STALL);

    // While stalled, pipe_vld is ignored so the queue owns the port.
    assign pipe_win_s = !stall_s && bus.pipe_vld && bus.pipe_rd_wen;
    assign pop_s      = !empty_s && (stall_s || !pipe_win_s);

`ifdef WB_ARB_BYPASS_EN
    assign bypass_s   = bus.ld_vld && empty_s && !pipe_win_s && !stall_s;
`else
    assign bypass_s   = 1'b0;
`endif

    assign push_s     = bus.ld_vld && !full_s && !bypass_s;
    assign drain_s    = pop_s && (fill_s == PTR_ONE) && !push_s;

    // Starvation counter next value: counts consecutive lost cycles, saturating.
    always_comb begin
        starve_nxt_s = starve_r;
        if (empty_s || pop_s) begin
            starve_nxt_s = 8'd0;
        end else if (starve_r < STARVE_LIM) begin
            starve_nxt_s = starve_r + 8'd1;
        end else begin
            starve_nxt_s = starve_r;
        end
    end

    // FSM next state.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (push_s) begin
                    state_nxt_s = QUEUED;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            QUEUED: begin
                if (drain_s) begin
                    state_nxt_s = IDLE;
                end else if (starve_nxt_s == STARVE_LIM) begin
                    state_nxt_s = STALL;
                end else begin
                    state_nxt_s = QUEUED;
                end
            end
            STALL: begin
                if (drain_s || (empty_s && !push_s)) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = STALL;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Write-port selection; address and data hold when the port is idle.
    always_comb begin
        wb_rd_nxt_s      = wb_rd_r;
        wb_rd_data_nxt_s = wb_rd_data_r;
        wb_rd_wen_nxt_s  = 1'b0;
        if (pipe_win_s) begin
            wb_rd_nxt_s      = bus.pipe_rd;
            wb_rd_data_nxt_s = bus.pipe_rd_data;
            wb_rd_wen_nxt_s  = (bus.pipe_rd != 5'd0);
        end else if (pop_s) begin
            wb_rd_nxt_s      = fifo_rd_r[head_idx_s];
            wb_rd_data_nxt_s = fifo_data_r[head_idx_s];
            wb_rd_wen_nxt_s  = fifo_wen_r[head_idx_s] && (fifo_rd_r[head_idx_s] != 5'd0);
        end else if (bypass_s) begin
            wb_rd_nxt_s      = bus.ld_rd;
            wb_rd_data_nxt_s = bus.ld_rd_data;
            wb_rd_wen_nxt_s  = (bus.ld_rd != 5'd0);
        end else begin
            wb_rd_wen_nxt_s  = 1'b0;
        end
    end

    // State, counter and write-port registers.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_r      <= IDLE;
            starve_r     <= 8'd0;
            wb_rd_r      <= 5'd0;
            wb_rd_data_r <= 32'd0;
            wb_rd_wen_r  <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            starve_r     <= starve_nxt_s;
            wb_rd_r      <= wb_rd_nxt_s;
            wb_rd_data_r <= wb_rd_data_nxt_s;
            wb_rd_wen_r  <= wb_rd_wen_nxt_s;
        end
    end

    // Load FIFO. The WAW kill runs before the push so a same-cycle load to the
    // same register (newer than the pipeline write) keeps its enable.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            wr_ptr_r   <= {(PTR_W+1){1'b0}};
            rd_ptr_r   <= {(PTR_W+1){1'b0}};
            fifo_wen_r <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                fifo_rd_r[i]   <= 5'd0;
                fifo_data_r[i] <= 32'd0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (pipe_win_s && (fifo_rd_r[i] == bus.pipe_rd)) begin
                    fifo_wen_r[i] <= 1'b0;
                end
            end
            if (push_s) begin
                fifo_rd_r[tail_idx_s]   <= bus.ld_rd;
                fifo_data_r[tail_idx_s] <= bus.ld_rd_data;
                fifo_wen_r[tail_idx_s]  <= 1'b1;
                wr_ptr_r                <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    assign bus.ld_rdy     = !full_s;
    assign bus.pipe_stall = stall_s;
    assign bus.ld_pending = !empty_s;
    assign bus.wb_rd      = wb_rd_r;
    assign bus.wb_rd_data = wb_rd_data_r;
    assign bus.wb_rd_wen  = wb_rd_wen_r;

endmodule
